// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 set-2 make/break/E0/E1 parser with per-key held state, strobes and parse watchdog.
// Define PS2_KEY_REPEAT_EN to let typematic repeats of held keys re-pulse key_press.
module ps2_key_tracker #(
    parameter int NUM_KEYS = 5,
    parameter logic [9*NUM_KEYS-1:0] KEY_CODES = {9'h02D, 9'h174, 9'h16B, 9'h172, 9'h175},
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          ps2_byte,
    input  logic                ps2_ready,
    input  logic                ps2_overflow,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [8:0]          code,
    output logic                code_make,
    output logic                code_valid,
    output logic                seq_error
);
`ifdef PS2_KEY_REPEAT_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif
    localparam int WW = $clog2(TIMEOUT_CYC);
    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;
    state_t state, state_n, from_idle;
    logic [2:0] cnt, cnt_n;
    logic [WW-1:0] wd;
    logic is_e0, is_f0, is_e1, is_pfx, ignored, done, make, err, timeout;
    logic [8:0] code9;
    always_comb begin
        is_e0 = ps2_byte == 8'hE0;
        is_f0 = ps2_byte == 8'hF0;
        is_e1 = ps2_byte == 8'hE1;
        is_pfx = is_e0 | is_f0 | is_e1;
        ignored = ps2_byte inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
        from_idle = is_e0 ? EXT : is_f0 ? BRK : is_e1 ? PAUSE : IDLE;
        timeout = state != IDLE && wd == WW'(TIMEOUT_CYC - 1);
        state_n = state;
        cnt_n = cnt;
        done = 1'b0;
        make = 1'b0;
        err = 1'b0;
        code9 = {1'b0, ps2_byte};
        if (ps2_overflow) begin
            state_n = IDLE;
        end else if (ps2_ready) begin
            // every entry into PAUSE comes from an E1 byte, so preloading outside PAUSE is harmless
            cnt_n = (state == PAUSE) ? cnt - 3'd1 : 3'd7;
            case (state)
                IDLE: begin
                    state_n = from_idle;
                    done = !is_pfx && !ignored;
                    make = 1'b1;
                end
                EXT: begin
                    state_n = is_e0 ? EXT : is_f0 ? EXT_BRK : is_e1 ? PAUSE : IDLE;
                    err = is_e1;
                    done = !is_pfx;
                    make = 1'b1;
                    code9[8] = 1'b1;
                end
                BRK, EXT_BRK: begin
                    state_n = from_idle;
                    err = is_pfx;
                    done = !is_pfx;
                    code9[8] = state == EXT_BRK;
                end
                default: state_n = (cnt == 3'd1) ? IDLE : PAUSE;
            endcase
        end else if (timeout) begin
            state_n = IDLE;
            err = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            wd <= '0;
            key_down <= '0;
            key_press <= '0;
            key_release <= '0;
            code <= '0;
            code_make <= 1'b0;
            code_valid <= 1'b0;
            seq_error <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            wd <= (state_n == IDLE || ps2_ready) ? '0 : wd + 1'b1;
            key_press <= '0;
            key_release <= ps2_overflow ? key_down : '0;
            code_valid <= done;
            seq_error <= err | ps2_overflow;
            if (ps2_overflow)
                key_down <= '0;
            if (done) begin
                code <= code9;
                code_make <= make;
                for (int i = 0; i < NUM_KEYS; i++)
                    if (KEY_CODES[9*i +: 9] == code9) begin
                        key_down[i] <= make;
                        key_press[i] <= make && (REPEAT || !key_down[i]);
                        key_release[i] <= !make && key_down[i];
                    end
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: directed scenarios plus random byte streams checked against a flag-based scan-code model.
module tb_ps2_key_tracker;
    localparam int NK = 5;
    localparam int TO = 16;
    localparam logic [9*NK-1:0] CODES = {9'h02D, 9'h174, 9'h16B, 9'h172, 9'h175};
`ifdef PS2_KEY_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, ps2_ready = 1'b0, ps2_overflow = 1'b0;
    logic [7:0] ps2_byte = 8'h00;
    logic [NK-1:0] key_down, key_press, key_release;
    logic [8:0] code;
    logic code_make, code_valid, seq_error;
    int checks = 0, failures = 0;
    bit m_ext, m_brk, e_make, e_valid, e_err;
    int m_pause;
    logic [NK-1:0] m_down, e_press, e_rel;
    logic [8:0] e_code;

    ps2_key_tracker #(.NUM_KEYS(NK), .KEY_CODES(CODES), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .ps2_byte(ps2_byte), .ps2_ready(ps2_ready),
        .ps2_overflow(ps2_overflow), .key_down(key_down), .key_press(key_press),
        .key_release(key_release), .code(code), .code_make(code_make),
        .code_valid(code_valid), .seq_error(seq_error)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_pause = 0; m_down = '0;
        e_press = '0; e_rel = '0; e_code = '0; e_make = 0; e_valid = 0; e_err = 0;
    endtask

    // m_ext/m_brk remember pending E0/F0 prefixes; m_pause counts bytes still swallowed by an E1 sequence
    task automatic model_byte(input logic [7:0] b);
        e_press = '0; e_rel = '0; e_valid = 0; e_err = 0;
        if (m_pause > 0) m_pause--;
        else if (b == 8'hE1) begin e_err = m_ext | m_brk; m_ext = 0; m_brk = 0; m_pause = 7; end
        else if (b == 8'hE0) begin e_err = m_brk; m_ext = 1; m_brk = 0; end
        else if (b == 8'hF0) begin e_err = m_brk; m_ext = m_ext & ~m_brk; m_brk = 1; end
        else if (m_ext || m_brk || !(b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
            e_code = {m_ext, b}; e_make = !m_brk; e_valid = 1;
            for (int i = 0; i < NK; i++)
                if (CODES[9*i +: 9] == e_code) begin
                    if (e_make) begin e_press[i] = REP || !m_down[i]; m_down[i] = 1'b1; end
                    else begin e_rel[i] = m_down[i]; m_down[i] = 1'b0; end
                end
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic model_overflow();
        e_rel = m_down; m_down = '0; e_press = '0; e_valid = 0; e_err = 1;
        m_ext = 0; m_brk = 0; m_pause = 0;
    endtask

    // called at a negedge; returns at the next negedge with the byte's results visible
    task automatic send(input logic [7:0] b);
        ps2_byte = b; ps2_ready = 1'b1; model_byte(b);
        @(negedge clk);
        ps2_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({key_down, key_press, key_release, code, code_make, code_valid, seq_error} !== '0) begin
            failures++;
            $display("FAIL reset got=%h exp=0", {key_down, key_press, key_release, code, code_make, code_valid, seq_error});
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_make_break();
        send(8'hE0); send(8'h75);
        checks++;
        if ({key_press, key_down, code, code_make, code_valid, seq_error} !== {5'b00001, 5'b00001, 9'h175, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL make_up got=%h exp=%h", {key_press, key_down, code, code_make, code_valid, seq_error},
                     {5'b00001, 5'b00001, 9'h175, 1'b1, 1'b1, 1'b0});
        end
        repeat (20) @(negedge clk);
        checks++;
        if ({key_down, key_press, code_valid} !== {5'b00001, 5'b0, 1'b0}) begin
            failures++;
            $display("FAIL hold_up got=%h exp=%h", {key_down, key_press, code_valid}, {5'b00001, 5'b0, 1'b0});
        end
        send(8'hE0); send(8'hF0); send(8'h75);
        checks++;
        if ({key_down, key_release, code, code_make, code_valid} !== {5'b0, 5'b00001, 9'h175, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL break_up got=%h exp=%h", {key_down, key_release, code, code_make, code_valid},
                     {5'b0, 5'b00001, 9'h175, 1'b0, 1'b1});
        end
    endtask

    task automatic test_unmapped();
        send(8'h75);
        checks++;
        if ({code, code_make, code_valid, key_down, key_press} !== {9'h075, 1'b1, 1'b1, 5'b0, 5'b0}) begin
            failures++;
            $display("FAIL keypad8 got=%h exp=%h", {code, code_make, code_valid, key_down, key_press},
                     {9'h075, 1'b1, 1'b1, 5'b0, 5'b0});
        end
    endtask

    task automatic test_typematic();
        int np = 0, nv = 0;
        repeat (3) begin
            send(8'hE0); np += int'(key_press[0]); nv += int'(code_valid);
            send(8'h75); np += int'(key_press[0]); nv += int'(code_valid);
        end
        checks++;
        if (np != (REP ? 3 : 1)) begin failures++; $display("FAIL typematic_press got=%0d exp=%0d", np, REP ? 3 : 1); end
        checks++;
        if (nv != 3) begin failures++; $display("FAIL typematic_valid got=%0d exp=3", nv); end
        send(8'hE0); send(8'hF0); send(8'h75);
    endtask

    task automatic test_overflow();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'h6B);
        checks++;
        if (key_down !== 5'b00101) begin failures++; $display("FAIL hold_two got=%b exp=00101", key_down); end
        ps2_overflow = 1'b1; ps2_ready = 1'b1; ps2_byte = 8'h2D; model_overflow();
        @(negedge clk);
        ps2_overflow = 1'b0; ps2_ready = 1'b0;
        checks++;
        if ({key_release, key_down, seq_error, key_press, code_valid} !== {5'b00101, 5'b0, 1'b1, 5'b0, 1'b0}) begin
            failures++;
            $display("FAIL overflow got=%h exp=%h", {key_release, key_down, seq_error, key_press, code_valid},
                     {5'b00101, 5'b0, 1'b1, 5'b0, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({seq_error, key_release} !== 6'b0) begin failures++; $display("FAIL overflow_pulse got=%b exp=0", {seq_error, key_release}); end
    endtask

    task automatic test_timeout();
        int k = 0;
        send(8'hE0);
        while (k < TO + 4 && seq_error !== 1'b1) begin @(negedge clk); k++; end
        checks++;
        if (seq_error !== 1'b1 || k != TO) begin
            failures++;
            $display("FAIL timeout got_err=%b at=%0d exp_err=1 at=%0d", seq_error, k, TO);
        end
        m_ext = 0;
        @(negedge clk);
        checks++;
        if (seq_error !== 1'b0) begin failures++; $display("FAIL timeout_pulse got=%b exp=0", seq_error); end
        send(8'h2D);
        checks++;
        if ({key_press, code} !== {5'b10000, 9'h02D}) begin
            failures++;
            $display("FAIL after_timeout got=%h exp=%h", {key_press, code}, {5'b10000, 9'h02D});
        end
        send(8'hF0); send(8'h2D);
    endtask

    task automatic test_pause();
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        int hits = 0;
        for (int i = 0; i < 8; i++) begin
            send(seq[i]);
            hits += int'(code_valid) + int'(seq_error) + int'(|key_press);
        end
        checks++;
        if (hits != 0) begin failures++; $display("FAIL pause_quiet got=%0d exp=0", hits); end
        send(8'h2D);
        checks++;
        if ({key_press, code_valid} !== {5'b10000, 1'b1}) begin
            failures++;
            $display("FAIL after_pause got=%h exp=%h", {key_press, code_valid}, {5'b10000, 1'b1});
        end
        send(8'hF0); send(8'h2D);
    endtask

    task automatic test_reset_mid();
        send(8'h2D); send(8'hE0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++;
        if ({key_down, key_press, key_release, code, code_make, code_valid, seq_error} !== '0) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=0", {key_down, key_press, key_release, code, code_make, code_valid, seq_error});
        end
        send(8'h75);
        checks++;
        if ({code, key_down} !== {9'h075, 5'b0}) begin
            failures++;
            $display("FAIL reset_drops_e0 got=%h exp=%h", {code, key_down}, {9'h075, 5'b0});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pal [12] = '{8'hE0, 8'hF0, 8'hE1, 8'h75, 8'h6B, 8'h72, 8'h74, 8'h2D, 8'h1C, 8'hAA, 8'h00, 8'hE0};
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(39) == 0) begin
                ps2_overflow = 1'b1; ps2_ready = 1'($urandom_range(1)); ps2_byte = pal[$urandom_range(11)];
                model_overflow();
                @(negedge clk);
                ps2_overflow = 1'b0; ps2_ready = 1'b0;
            end else begin
                send(pal[$urandom_range(11)]);
            end
            checks++;
            if ({key_down, key_press, key_release, code, code_make, code_valid, seq_error} !==
                {m_down, e_press, e_rel, e_code, e_make, e_valid, e_err}) begin
                failures++;
                $display("FAIL random_byte n=%0d got=%h exp=%h", n,
                         {key_down, key_press, key_release, code, code_make, code_valid, seq_error},
                         {m_down, e_press, e_rel, e_code, e_make, e_valid, e_err});
            end
            repeat ($urandom_range(2)) begin
                @(negedge clk);
                checks++;
                if ({key_press, key_release, code_valid, seq_error, key_down} !== {5'b0, 5'b0, 1'b0, 1'b0, m_down}) begin
                    failures++;
                    $display("FAIL random_gap n=%0d got=%h exp=%h", n,
                             {key_press, key_release, code_valid, seq_error, key_down}, {5'b0, 5'b0, 1'b0, 1'b0, m_down});
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_make_break();
        test_unmapped();
        test_typematic();
        test_overflow();
        test_timeout();
        test_pause();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
